// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote tally block.
package vote_pkg;

    // Session FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StTally,
        StResult
    } vote_state_e;

    // Width needed to hold a count of 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Simple majority: more than half of the voters.
    function automatic int unsigned default_threshold(input int unsigned n);
        return n / 2 + 1;
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of an N-bit mask.
module vote_popcount
    import vote_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]              mask,
    output logic [cnt_width(N)-1:0]   count
);

    localparam int unsigned Cw = cnt_width(N);

    // Sum the set bits.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + Cw'(mask[i]);
        end
    end

endmodule

// File: rtl/vote_tally_fsm.sv
// Voting session controller: locks one YES/NO vote per voter, tallies at close,
// and holds the verdict until the next session is started.
// Optional feature macro VOTE_TIMEOUT_EN adds a session timeout counter.
module vote_tally_fsm
    import vote_pkg::*;
#(
    parameter int unsigned N_VOTERS  = 4,
    parameter int unsigned THRESHOLD = default_threshold(N_VOTERS)
`ifdef VOTE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = 1000
`endif
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              close,
    input  logic [N_VOTERS-1:0]               yes,
    input  logic [N_VOTERS-1:0]               no,
    output logic [N_VOTERS-1:0]               voted,
    output logic [cnt_width(N_VOTERS)-1:0]    yes_cnt,
    output logic [cnt_width(N_VOTERS)-1:0]    no_cnt,
    output logic                              pass,
    output logic                              tie,
    output logic                              done,
    output logic                              busy
);

    localparam int unsigned   Cw  = cnt_width(N_VOTERS);
    localparam logic [Cw-1:0] Thr = Cw'(THRESHOLD);

    vote_state_e         state_q, state_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [N_VOTERS-1:0] choice_q, choice_d;  // 1 = YES, meaningful only where voted_q
    logic [N_VOTERS-1:0] lock;
    logic [Cw-1:0]       yes_cnt_q, yes_cnt_d;
    logic [Cw-1:0]       no_cnt_q, no_cnt_d;
    logic [Cw-1:0]       yes_pop, no_pop;
    logic                session_start;
    logic                timeout;

    assign session_start = start && (state_q == StIdle || state_q == StResult);

`ifdef VOTE_TIMEOUT_EN
    localparam int unsigned Tw = $clog2(TIMEOUT + 1);
    logic [Tw-1:0] timer_q, timer_d;

    // Session timer: load on entry to OPEN, count down while OPEN.
    always_comb begin
        timer_d = timer_q;
        if (session_start) begin
            timer_d = Tw'(TIMEOUT);
        end else if (state_q == StOpen && timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end
    end

    // Timer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // Close on the cycle whose edge brings the counter to zero.
    assign timeout = (state_q == StOpen) && (timer_q <= Tw'(1));
`else
    assign timeout = 1'b0;
`endif

    vote_popcount #(
        .N (N_VOTERS)
    ) u_yes_pop (
        .mask  (voted_q & choice_q),
        .count (yes_pop)
    );

    vote_popcount #(
        .N (N_VOTERS)
    ) u_no_pop (
        .mask  (voted_q & ~choice_q),
        .count (no_pop)
    );

    // Next-state, vote-lock and output decode.
    always_comb begin
        state_d   = state_q;
        voted_d   = voted_q;
        choice_d  = choice_q;
        yes_cnt_d = yes_cnt_q;
        no_cnt_d  = no_cnt_q;
        lock      = '0;

        case (state_q)
            StIdle, StResult: begin
                if (start) begin
                    state_d   = StOpen;
                    voted_d   = '0;
                    choice_d  = '0;
                    yes_cnt_d = '0;
                    no_cnt_d  = '0;
                end
            end
            StOpen: begin
                // Exactly one of YES/NO from a voter that has not locked yet.
                lock     = (yes ^ no) & ~voted_q;
                voted_d  = voted_q | lock;
                choice_d = choice_q | (lock & yes);
                if (close || (&voted_q) || timeout) begin
                    state_d = StTally;
                end
            end
            StTally: begin
                yes_cnt_d = yes_pop;
                no_cnt_d  = no_pop;
                state_d   = StResult;
            end
            default: state_d = StIdle;
        endcase

        done = (state_q == StResult);
        busy = (state_q == StOpen) || (state_q == StTally);
        pass = done && (yes_cnt_q >= Thr);
        tie  = done && (yes_cnt_q == no_cnt_q);
    end

    // State and vote registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            voted_q   <= '0;
            choice_q  <= '0;
            yes_cnt_q <= '0;
            no_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            voted_q   <= voted_d;
            choice_q  <= choice_d;
            yes_cnt_q <= yes_cnt_d;
            no_cnt_q  <= no_cnt_d;
        end
    end

    assign voted   = voted_q;
    assign yes_cnt = yes_cnt_q;
    assign no_cnt  = no_cnt_q;

endmodule
